// File: rtl/timer_sched.sv
// timer_sched: round-robin sharing of one non-recycling down-counter
// between NREQ requesters. Each requester is granted the counter in turn.
// The counter is loaded with the requester's interval and run to terminal
// count, and the requester then receives a one-cycle completion pulse.
//
// Optional feature: define TIMER_SCHED_ABORT_EN to let a requester cancel
// its service by dropping req while in LOAD or RUN. When the macro is left
// undefined, withdrawal after grant is ignored and service always completes.

module timer_sched #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  cnt_loadn,
    output logic [WIDTH-1:0]      cnt_in,
    output logic                  cnt_en,
    input  logic                  cnt_out
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   ptr_q,   ptr_d;
    logic [IDXW-1:0]   gidx_q,  gidx_d;
    logic [WIDTH-1:0]  len_q,   len_d;
    logic [NREQ-1:0]   gnt_q,   gnt_d;

    logic [IDXW-1:0]   pickIdx;
    logic [WIDTH-1:0]  pickLen;
    logic              abortReq;

    // Walk upward from ptr+1 (wrapping at NREQ) and return the first
    // asserted requester; only meaningful when r is nonzero.
    function automatic logic [IDXW-1:0] rrPick(input logic [IDXW-1:0] ptr,
                                               input logic [NREQ-1:0] r);
        logic [IDXW-1:0] c;
        logic            found;
        c      = ptr;
        found  = 1'b0;
        rrPick = ptr;
        for (int k = 0; k < NREQ; k++) begin
            c = (c == IDXW'(NREQ - 1)) ? '0 : c + IDXW'(1);
            if (!found && r[c]) begin
                rrPick = c;
                found  = 1'b1;
            end
        end
    endfunction

    // Pick the next requester and the interval it asks for.
    always_comb begin
        pickIdx = rrPick(ptr_q, req);
        pickLen = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(pickIdx) == i) begin
                pickLen = len[i*WIDTH +: WIDTH];
            end
        end
    end

    // Detect withdrawal of the request currently being served.
    always_comb begin
`ifdef TIMER_SCHED_ABORT_EN
        abortReq = !req[gidx_q];
`else
        abortReq = 1'b0;
`endif
    end

    // State, grant, pointer and latched-interval registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            ptr_q   <= IDXW'(NREQ - 1);
            gidx_q  <= '0;
            len_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            len_q   <= len_d;
            gnt_q   <= gnt_d;
        end
    end

    // Next-state logic: grant in IDLE, one LOAD cycle, RUN until terminal, DONE pulse.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        len_d   = len_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gidx_d  = pickIdx;
                    len_d   = pickLen;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pickIdx;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abortReq) begin
                    ptr_d   = gidx_q;
                    gnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abortReq) begin
                    ptr_d   = gidx_q;
                    gnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_out) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ptr_d   = gidx_q;
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Moore outputs decoded from registered state and registered grant.
    always_comb begin
        gnt       = gnt_q;
        busy      = (state_q != IDLE);
        cnt_loadn = 1'b1;
        cnt_in    = '0;
        cnt_en    = 1'b0;
        done      = '0;
        case (state_q)
            LOAD: begin
                cnt_loadn = 1'b0;
                cnt_in    = len_q;
            end
            RUN: begin
                cnt_en = 1'b1;
            end
            DONE: begin
                done = gnt_q;
            end
            default: begin
                cnt_loadn = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_timer_sched.sv
// Testbench for timer_sched: directed scenarios followed by randomized
// request traffic, checked every cycle against a service-timeline model.
// Honours TIMER_SCHED_ABORT_EN the same way as the design.

module tb_timer_sched;

    localparam int WIDTH = 4;
    localparam int NREQ  = 4;

    logic                  clk  = 1'b0;
    logic                  clrn = 1'b1;
    logic [NREQ-1:0]       req  = '0;
    logic [NREQ*WIDTH-1:0] len  = '0;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic                  cnt_loadn;
    logic [WIDTH-1:0]      cnt_in;
    logic                  cnt_en;
    logic                  cnt_out;

    logic [WIDTH-1:0]      ctr = '0;

    int checks = 0;
    int errors = 0;

    // Reference model: where we are in the current service, measured in
    // cycles since the grant edge.
    bit mBusy = 1'b0;
    int mG    = 0;
    int mL    = 0;
    int mT    = 0;
    int mPtr  = NREQ - 1;

    timer_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .req       (req),
        .len       (len),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .cnt_loadn (cnt_loadn),
        .cnt_in    (cnt_in),
        .cnt_en    (cnt_en),
        .cnt_out   (cnt_out)
    );

    // System clock.
    always #5 clk = ~clk;

    // Shared down-counter: synchronous load, holds at zero, never reset.
    always @(posedge clk) begin
        if (!cnt_loadn)
            ctr <= cnt_in;
        else if (cnt_en && ctr != 0)
            ctr <= ctr - 1'b1;
    end
    assign cnt_out = (ctr == 0);

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mBusy = 1'b0;
        mG    = 0;
        mL    = 0;
        mT    = 0;
        mPtr  = NREQ - 1;
    endtask

    // Advance the model by one clock edge using the inputs sampled there.
    task automatic modelStep();
        bit abortNow;
        if (!mBusy) begin
            if (req != 0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int c;
                    c = (mPtr + k) % NREQ;
                    if (!mBusy && req[c]) begin
                        mBusy = 1'b1;
                        mG    = c;
                        mL    = int'(len[c*WIDTH +: WIDTH]);
                        mT    = 0;
                    end
                end
            end
        end else begin
            abortNow = 1'b0;
`ifdef TIMER_SCHED_ABORT_EN
            abortNow = !req[mG] && (mT <= mL + 1);
`endif
            if (abortNow || mT == mL + 2) begin
                mBusy = 1'b0;
                mPtr  = mG;
            end else begin
                mT++;
            end
        end
    endtask

    task automatic checkAll(input string ph);
        logic [NREQ-1:0]  eGnt, eDone;
        logic             eLoadn, eEn;
        logic [WIDTH-1:0] eIn;
        eGnt   = mBusy ? NREQ'(1) << mG : '0;
        eDone  = (mBusy && mT == mL + 2) ? NREQ'(1) << mG : '0;
        eLoadn = !(mBusy && mT == 0);
        eIn    = (mBusy && mT == 0) ? WIDTH'(mL) : '0;
        eEn    = mBusy && mT >= 1 && mT <= mL + 1;
        checkOutput({ph, ".busy"},  32'(busy),      32'(mBusy));
        checkOutput({ph, ".gnt"},   32'(gnt),       32'(eGnt));
        checkOutput({ph, ".done"},  32'(done),      32'(eDone));
        checkOutput({ph, ".loadn"}, 32'(cnt_loadn), 32'(eLoadn));
        checkOutput({ph, ".cntin"}, 32'(cnt_in),    32'(eIn));
        checkOutput({ph, ".cnten"}, 32'(cnt_en),    32'(eEn));
    endtask

    task automatic applyReset();
        clrn = 1'b0;
        #1;
        modelReset();
        checkAll("rst");
        @(posedge clk);
        @(negedge clk);
        checkAll("rsthold");
        clrn = 1'b1;
    endtask

    // Random request traffic that respects hold-until-done.
    task automatic applyStimulus();
        for (int i = 0; i < NREQ; i++) begin
            if (mBusy && mT == mL + 2 && mG == i) begin
                if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                req[i] = 1'b1;
            end
            if ($urandom_range(0, 5) == 0)
                len[i*WIDTH +: WIDTH] = ($urandom_range(0, 7) == 0) ?
                    WIDTH'($urandom_range(0, (1 << WIDTH) - 1)) : WIDTH'($urandom_range(0, 4));
        end
`ifdef TIMER_SCHED_ABORT_EN
        if (mBusy && mT <= mL + 1 && $urandom_range(0, 19) == 0)
            req[mG] = 1'b0;
`endif
    endtask

    task automatic runCycles(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (clrn) modelStep();
            @(negedge clk);
            checkAll(rnd ? "rand" : "dir");
            if (rnd) applyStimulus();
        end
    endtask

    initial begin
        #2;
        applyReset();

        // Single request, interval 3.
        len = '0;
        len[3:0] = 4'd3;
        req = 4'b0001;
        runCycles(7, 1'b0);
        req = '0;
        runCycles(2, 1'b0);

        // Fairness with all requesters pending, interval 1 each.
        len = {NREQ{4'd1}};
        req = 4'b1111;
        runCycles(24, 1'b0);
        req = '0;
        runCycles(6, 1'b0);

        // Zero-length interval on requester 2.
        len = {NREQ{4'd5}};
        len[11:8] = 4'd0;
        req = 4'b0100;
        runCycles(3, 1'b0);
        req = '0;
        runCycles(2, 1'b0);

        // Reset in the middle of RUN, then requester 0 must win first.
        len[11:8] = 4'd9;
        req = 4'b0100;
        runCycles(4, 1'b0);
        applyReset();
        len[3:0] = 4'd2;
        len[11:8] = 4'd2;
        req = 4'b0101;
        runCycles(14, 1'b0);
        req = '0;
        runCycles(4, 1'b0);

        // Interval change after grant is ignored.
        len[3:0] = 4'd5;
        req = 4'b0001;
        runCycles(2, 1'b0);
        len[3:0] = 4'd9;
        runCycles(6, 1'b0);
        req = '0;
        runCycles(3, 1'b0);

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            runCycles(1, 1'b1);
            if ($urandom_range(0, 249) == 0) applyReset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
